pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Game sequencer for the Pong datapath; owns all game state consumed by the pixel renderer: paddle Y, ball X/Y, collision flag, game_over.
- Advances the game once per video frame (frame_tick) through IDLE/SERVE/PLAY/POINT/GAME_OVER.
- Moves the player paddle from buttons and runs the CPU paddle tracker.
- Coordinates are cartesian, origin at bottom-left: x 0..639, y 0..479; positions are the left/bottom edge of each object.

Parameters:
- BALL_SPEED, 2, ball pixels per frame on each axis
- P1_SPEED, 4, player paddle pixels per frame
- CPU_SPEED, 3, max CPU paddle pixels per frame
- WIN_SCORE, 5, points needed to end the game
- SERVE_FRAMES, 60, frames the ball holds at centre before launch
- P1_X, 64, player paddle column
- CPU_X, 576, CPU paddle column
- PAD_H, 64, paddle height
- BALL_W, 3, ball width and height
- SCR_W, 640, screen width
- SCR_H, 480, screen height

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame
- start  in  1  level; begin or restart a game
- btn_up  in  1  player paddle up
- btn_down  in  1  player paddle down
- p1_posy  out  10  player paddle bottom
- cpu_posy  out  10  CPU paddle bottom
- ball_posx  out  10  ball left edge
- ball_posy  out  10  ball bottom edge
- collision  out  1  one-cycle pulse on a paddle hit
- game_over  out  1  high while in GAME_OVER
- p1_score  out  4  player score
- cpu_score  out  4  CPU score

Behaviour:
- Reset (async, immediate): state=IDLE; ball=(318,238); p1_posy=cpu_posy=208; scores=0; collision=0; game_over=0; dir_x=+1; dir_y=+1; serve counter=0.
- All outputs are registered. State and positions change only on clock edges with frame_tick=1, except start handling in IDLE and GAME_OVER. Latency is 1 clock from tick to the new values.
- collision is high for exactly the one clock following the tick that detected the hit.
- IDLE: everything frozen.
  - start=1 -> SERVE. Clears scores, loads serve counter=SERVE_FRAMES, centres the ball, sets dir_x=+1.
  - If start and frame_tick are high in the same cycle, only the start action is taken.
- SERVE: on each tick, paddles update and the counter decrements. The tick on which the counter reads 1 -> PLAY; the ball does not move in SERVE.
- PLAY: on each tick, paddles update first, then the ball. Compute nx = x + dir_x*BALL_SPEED and ny = y + dir_y*BALL_SPEED in signed 11-bit.
  - Wall: if ny<=0, set y=0 and dir_y=+1. If ny>=SCR_H-BALL_W, set y=477 and dir_y=-1.
  - Player hit: dir_x=-1, x>P1_X, nx<=P1_X, and ball_y+BALL_W-1>=p1_posy and ball_y<=p1_posy+PAD_H-1 (pre-move y). Then x=P1_X+1, dir_x=+1, collision=1.
  - CPU hit: dir_x=+1, x+BALL_W-1<CPU_X, nx+BALL_W-1>=CPU_X, and the same overlap test against cpu_posy. Then x=CPU_X-BALL_W, dir_x=-1, collision=1.
  - Miss: nx<=0 gives cpu_score+1 and x=0. nx>=SCR_W-BALL_W gives p1_score+1 and x=637. Either -> POINT. The paddle test has priority over the miss test.
- POINT, on the next tick:
  - If the incremented score equals WIN_SCORE -> GAME_OVER, with the ball frozen at its edge position.
  - Otherwise -> SERVE: ball centred, counter reloaded, dir_x points toward the player who lost the point, dir_y kept.
- GAME_OVER: game_over=1, all motion frozen. start=1 -> SERVE with scores cleared and game_over=0 on the next clock.
- Player paddle:
  - up only: +P1_SPEED, saturating at SCR_H-PAD_H=416.
  - down only: -P1_SPEED, saturating at 0.
  - both or neither: hold.
- CPU paddle:
  - target = ball_posy+1-PAD_H/2, clamped to 0..416.
  - Moves toward target by min(|diff|, CPU_SPEED) per tick.
- Scores never exceed WIN_SCORE. Scores are 4-bit; WIN_SCORE must be ≤15.
- Reset mid-operation overrides everything within the same cycle, including a pending collision pulse.

Test Plan:
- Reset: assert rst mid-PLAY, asynchronous to clk -> outputs show reset values before the next edge (ball 318,238; paddles 208; game_over 0).
- Serve timing: start, then ticks -> ball stays (318,238) for 60 ticks. The 61st tick gives ball (320,240); collision=0.
- Player clamp: hold btn_up from 208 for 60 ticks -> 416 after tick 52, then stays 416. Both buttons held -> no change.
- Top wall bounce: drive play until ball_posy=476 with dir_y=+1 -> next tick y=477, the following tick y=475.
- CPU hit: CPU paddle tracking a slow ball -> hit yields ball_posx=573 and a single collision pulse. On the next tick x=571.
- Game over: player holds no buttons and the ball is served toward P1 -> cpu_score increments per miss. At 5, game_over=1 and the ball freezes. start clears scores and game_over and enters SERVE.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// Control and game-state bundle between the Pong sequencer and its driver/renderer.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       btn_up;
    logic       btn_down;
    logic [9:0] p1_posy;
    logic [9:0] cpu_posy;
    logic [9:0] ball_posx;
    logic [9:0] ball_posy;
    logic       collision;
    logic       game_over;
    logic [3:0] p1_score;
    logic [3:0] cpu_score;

    modport master (
        output frame_tick, start, btn_up, btn_down,
        input  p1_posy, cpu_posy, ball_posx, ball_posy,
        input  collision, game_over, p1_score, cpu_score
    );

    modport slave (
        input  frame_tick, start, btn_up, btn_down,
        output p1_posy, cpu_posy, ball_posx, ball_posy,
        output collision, game_over, p1_score, cpu_score
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: per-frame paddle/ball update, scoring and serve/game-over flow.
module pong_game_ctrl #(
    parameter int BALL_SPEED   = 2,
    parameter int P1_SPEED     = 4,
    parameter int CPU_SPEED    = 3,
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int P1_X         = 64,
    parameter int CPU_X        = 576,
    parameter int PAD_H        = 64,
    parameter int BALL_W       = 3,
    parameter int SCR_W        = 640,
    parameter int SCR_H        = 480
) (
    input  logic             clk,
    input  logic             rst,
    pong_game_ctrl_if.slave  bus
);
    typedef logic signed [10:0] s11_t;
    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, GAME_OVER} state_t;

    localparam int         CW       = $clog2(SERVE_FRAMES + 1);
    localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0] WIN      = 4'(WIN_SCORE);
    localparam logic [9:0] BX0      = 10'((SCR_W - BALL_W) / 2);
    localparam logic [9:0] BY0      = 10'((SCR_H - BALL_W) / 2);
    localparam logic [9:0] PY0      = 10'((SCR_H - PAD_H) / 2);
    localparam logic [9:0] BX_P1    = 10'(P1_X + 1);
    localparam logic [9:0] BX_CPU   = 10'(CPU_X - BALL_W);
    localparam logic [9:0] BX_RIGHT = 10'(SCR_W - BALL_W);
    localparam logic [9:0] BY_TOP   = 10'(SCR_H - BALL_W);
    localparam s11_t ZERO    = '0;
    localparam s11_t ONE     = s11_t'(1);
    localparam s11_t PAD_MAX = s11_t'(SCR_H - PAD_H);
    localparam s11_t X_MAX   = s11_t'(SCR_W - BALL_W);
    localparam s11_t Y_MAX   = s11_t'(SCR_H - BALL_W);
    localparam s11_t V_BALL  = s11_t'(BALL_SPEED);
    localparam s11_t V_P1    = s11_t'(P1_SPEED);
    localparam s11_t V_CPU   = s11_t'(CPU_SPEED);
    localparam s11_t X_P1    = s11_t'(P1_X);
    localparam s11_t X_CPU   = s11_t'(CPU_X);
    localparam s11_t BW1     = s11_t'(BALL_W - 1);
    localparam s11_t PH1     = s11_t'(PAD_H - 1);
    localparam s11_t PHALF   = s11_t'(PAD_H / 2);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [9:0]    p1_y, cpu_y, bx, by;
    logic [9:0]    p1_nxt, cpu_nxt, bx_nxt, by_nxt;
    logic          dir_x, dir_y, dx_nxt, dy_nxt;   // 1 = moving toward larger coordinate
    logic          col, col_nxt, go, go_nxt;
    logic [3:0]    s1, s2, s1_nxt, s2_nxt;

    s11_t p1_s, cpu_s, bx_s, by_s;
    s11_t p1_mv, cpu_mv, tgt, diff, nx, ny;
    logic ov_p1, ov_cpu, hit_p1, hit_cpu;

    // Candidate paddle moves and ball geometry, all in signed 11-bit.
    always_comb begin
        p1_s  = s11_t'(p1_y);
        cpu_s = s11_t'(cpu_y);
        bx_s  = s11_t'(bx);
        by_s  = s11_t'(by);

        p1_mv = p1_s;
        if (bus.btn_up && !bus.btn_down)
            p1_mv = (p1_s + V_P1 >= PAD_MAX) ? PAD_MAX : p1_s + V_P1;
        else if (bus.btn_down && !bus.btn_up)
            p1_mv = (p1_s <= V_P1) ? ZERO : p1_s - V_P1;

        tgt = by_s + ONE - PHALF;
        if (tgt[10])            tgt = ZERO;
        else if (tgt > PAD_MAX) tgt = PAD_MAX;
        diff = tgt - cpu_s;
        if (diff > V_CPU)       cpu_mv = cpu_s + V_CPU;
        else if (diff < -V_CPU) cpu_mv = cpu_s - V_CPU;
        else                    cpu_mv = tgt;

        nx = dir_x ? bx_s + V_BALL : bx_s - V_BALL;
        ny = dir_y ? by_s + V_BALL : by_s - V_BALL;

        // Overlap uses the pre-move ball y against the freshly moved paddles.
        ov_p1   = (by_s + BW1 >= p1_mv)  && (by_s <= p1_mv + PH1);
        ov_cpu  = (by_s + BW1 >= cpu_mv) && (by_s <= cpu_mv + PH1);
        hit_p1  = !dir_x && (bx_s > X_P1) && (nx <= X_P1) && ov_p1;
        hit_cpu = dir_x && (bx_s + BW1 < X_CPU) && (nx + BW1 >= X_CPU) && ov_cpu;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        p1_nxt    = p1_y;
        cpu_nxt   = cpu_y;
        bx_nxt    = bx;
        by_nxt    = by;
        dx_nxt    = dir_x;
        dy_nxt    = dir_y;
        col_nxt   = 1'b0;
        go_nxt    = go;
        s1_nxt    = s1;
        s2_nxt    = s2;
        case (state)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_nxt = SERVE;
                    cnt_nxt   = SERVE_LD;
                    s1_nxt    = '0;
                    s2_nxt    = '0;
                    bx_nxt    = BX0;
                    by_nxt    = BY0;
                    dx_nxt    = 1'b1;
                    go_nxt    = 1'b0;
                end
            end
            SERVE: begin
                if (bus.frame_tick) begin
                    p1_nxt  = p1_mv[9:0];
                    cpu_nxt = cpu_mv[9:0];
                    cnt_nxt = cnt - CNT_ONE;
                    if (cnt == CNT_ONE) state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (bus.frame_tick) begin
                    p1_nxt  = p1_mv[9:0];
                    cpu_nxt = cpu_mv[9:0];
                    if (ny <= ZERO) begin
                        by_nxt = '0;
                        dy_nxt = 1'b1;
                    end else if (ny >= Y_MAX) begin
                        by_nxt = BY_TOP;
                        dy_nxt = 1'b0;
                    end else begin
                        by_nxt = ny[9:0];
                    end
                    if (hit_p1) begin
                        bx_nxt  = BX_P1;
                        dx_nxt  = 1'b1;
                        col_nxt = 1'b1;
                    end else if (hit_cpu) begin
                        bx_nxt  = BX_CPU;
                        dx_nxt  = 1'b0;
                        col_nxt = 1'b1;
                    end else if (nx <= ZERO) begin
                        s2_nxt    = s2 + 4'd1;
                        bx_nxt    = '0;
                        state_nxt = POINT;
                    end else if (nx >= X_MAX) begin
                        s1_nxt    = s1 + 4'd1;
                        bx_nxt    = BX_RIGHT;
                        state_nxt = POINT;
                    end else begin
                        bx_nxt = nx[9:0];
                    end
                end
            end
            POINT: begin
                // dir_x still points at the side that missed, i.e. toward the loser.
                if (bus.frame_tick) begin
                    if (s1 == WIN || s2 == WIN) begin
                        state_nxt = GAME_OVER;
                        go_nxt    = 1'b1;
                    end else begin
                        state_nxt = SERVE;
                        cnt_nxt   = SERVE_LD;
                        bx_nxt    = BX0;
                        by_nxt    = BY0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            p1_y  <= PY0;
            cpu_y <= PY0;
            bx    <= BX0;
            by    <= BY0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
            col   <= 1'b0;
            go    <= 1'b0;
            s1    <= '0;
            s2    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            p1_y  <= p1_nxt;
            cpu_y <= cpu_nxt;
            bx    <= bx_nxt;
            by    <= by_nxt;
            dir_x <= dx_nxt;
            dir_y <= dy_nxt;
            col   <= col_nxt;
            go    <= go_nxt;
            s1    <= s1_nxt;
            s2    <= s2_nxt;
        end
    end

    assign bus.p1_posy   = p1_y;
    assign bus.cpu_posy  = cpu_y;
    assign bus.ball_posx = bx;
    assign bus.ball_posy = by;
    assign bus.collision = col;
    assign bus.game_over = go;
    assign bus.p1_score  = s1;
    assign bus.cpu_score = s2;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: random play against a rule-level game model, plus reset/serve/game-over checks.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pong_game_ctrl_if bus();
    pong_game_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [9:0] p1, cpu, bx, by;
        logic       col, go;
        logic [3:0] s1, s2;
    } snap_t;

    typedef struct {
        int mode;   // 0 idle, 1 serving, 2 rally, 3 point scored, 4 over
        int serve, bx, by, dx, dy, p1, cpu, s1, s2, col, over, p1_lost;
    } game_t;

    game_t m;
    snap_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    function automatic snap_t model_snap();
        snap_t s;
        s.p1 = 10'(m.p1);  s.cpu = 10'(m.cpu);
        s.bx = 10'(m.bx);  s.by  = 10'(m.by);
        s.col = (m.col != 0); s.go = (m.over != 0);
        s.s1 = 4'(m.s1);   s.s2 = 4'(m.s2);
        return s;
    endfunction

    task automatic model_reset();
        m = '{mode:0, serve:0, bx:318, by:238, dx:1, dy:1, p1:208, cpu:208,
              s1:0, s2:0, col:0, over:0, p1_lost:0};
    endtask

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic move_paddles(input bit up, input bit dn);
        int t, d;
        if (up && !dn) m.p1 = clampi(m.p1 + 4, 0, 416);
        if (dn && !up) m.p1 = clampi(m.p1 - 4, 0, 416);
        t = clampi(m.by + 1 - 32, 0, 416);
        d = clampi(t - m.cpu, -3, 3);
        m.cpu = m.cpu + d;
    endtask

    task automatic move_ball();
        int nx, ny, y0;
        y0 = m.by;
        nx = m.bx + 2 * m.dx;
        ny = m.by + 2 * m.dy;
        if (ny <= 0)        begin m.by = 0;   m.dy = 1;  end
        else if (ny >= 477) begin m.by = 477; m.dy = -1; end
        else m.by = ny;
        if (m.dx < 0 && m.bx > 64 && nx <= 64 && y0 + 2 >= m.p1 && y0 <= m.p1 + 63) begin
            m.bx = 65; m.dx = 1; m.col = 1;
        end else if (m.dx > 0 && m.bx + 2 < 576 && nx + 2 >= 576 && y0 + 2 >= m.cpu && y0 <= m.cpu + 63) begin
            m.bx = 573; m.dx = -1; m.col = 1;
        end else if (nx <= 0) begin
            m.s2++; m.bx = 0; m.p1_lost = 1; m.mode = 3;
        end else if (nx >= 637) begin
            m.s1++; m.bx = 637; m.p1_lost = 0; m.mode = 3;
        end else m.bx = nx;
    endtask

    task automatic model_step(input bit tk, input bit st, input bit up, input bit dn);
        m.col = 0;
        if ((m.mode == 0 || m.mode == 4) && st) begin
            m.s1 = 0; m.s2 = 0; m.serve = 60; m.bx = 318; m.by = 238;
            m.dx = 1; m.over = 0; m.mode = 1;
            return;
        end
        if (!tk) return;
        case (m.mode)
            1: begin
                move_paddles(up, dn);
                if (m.serve == 1) m.mode = 2;
                m.serve--;
            end
            2: begin
                move_paddles(up, dn);
                move_ball();
            end
            3: begin
                if (m.s1 == 5 || m.s2 == 5) begin
                    m.mode = 4; m.over = 1;
                end else begin
                    m.bx = 318; m.by = 238; m.serve = 60; m.mode = 1;
                    m.dx = m.p1_lost ? -1 : 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit tk, input bit st, input bit up, input bit dn);
        @(negedge clk);
        bus.frame_tick = tk; bus.start = st; bus.btn_up = up; bus.btn_down = dn;
        model_step(tk, st, up, dn);
        exp_q.push_back(model_snap());
    endtask

    task automatic chk(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    // Monitor: outputs are registered, so each clock's expectation is checked just after its edge.
    initial forever begin
        snap_t e, a;
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.p1_posy, bus.cpu_posy, bus.ball_posx, bus.ball_posy,
                 bus.collision, bus.game_over, bus.p1_score, bus.cpu_score};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL sb cyc=%0d got p1=%0d cpu=%0d bx=%0d by=%0d col=%0b go=%0b s=%0d/%0d want p1=%0d cpu=%0d bx=%0d by=%0d col=%0b go=%0b s=%0d/%0d",
                         cyc, a.p1, a.cpu, a.bx, a.by, a.col, a.go, a.s1, a.s2,
                         e.p1, e.cpu, e.bx, e.by, e.col, e.go, e.s1, e.s2);
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_bx"},  int'(bus.ball_posx), 318);
        chk({tag, "_by"},  int'(bus.ball_posy), 238);
        chk({tag, "_p1"},  int'(bus.p1_posy),   208);
        chk({tag, "_cpu"}, int'(bus.cpu_posy),  208);
        chk({tag, "_go"},  int'(bus.game_over), 0);
        chk({tag, "_col"}, int'(bus.collision), 0);
        chk({tag, "_s"},   int'(bus.p1_score) + int'(bus.cpu_score), 0);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, frz_bx, frz_p1;
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;

        // IDLE is frozen even with ticks and buttons
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        // start and tick together: only the start action; then hold up through the serve
        step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("serve_hold_bx", int'(bus.ball_posx), 318);
        chk("serve_hold_by", int'(bus.ball_posy), 238);
        chk("p1_clamp_top",  int'(bus.p1_posy),   416);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("launch_bx",  int'(bus.ball_posx), 320);
        chk("launch_by",  int'(bus.ball_posy), 240);
        chk("launch_col", int'(bus.collision), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("both_btn_hold", int'(bus.p1_posy), 416);

        // random play
        for (int i = 0; i < 3000 && fails < 30; i++)
            step(bit'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        // asynchronous reset in the middle of a rally
        guard = 0;
        while (m.mode != 2 && guard < 400) begin
            step(1'b1, (m.mode == 0 || m.mode == 4), 1'b0, 1'b0);
            guard++;
        end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("reach_play", m.mode, 2);
        @(posedge clk);
        #3;
        bus.frame_tick = 1'b0; bus.start = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
        rst = 1'b1;
        #1;
        chk_reset_vals("arst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // full game with an idle player until someone reaches the win score
        step(1'b0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m.over == 0 && guard < 40000 && fails < 30) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("go_reached", int'(bus.game_over), 1);
        chk("go_cpu_score", int'(bus.cpu_score), m.s2);
        chk("go_p1_score",  int'(bus.p1_score),  m.s1);
        frz_bx = m.bx;
        frz_p1 = m.p1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("go_frozen_bx", int'(bus.ball_posx), frz_bx);
        chk("go_frozen_p1", int'(bus.p1_posy),   frz_p1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("restart_go", int'(bus.game_over), 0);
        chk("restart_s",  int'(bus.p1_score) + int'(bus.cpu_score), 0);
        chk("restart_bx", int'(bus.ball_posx), 318);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
